// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: sequencer state encoding and
// the default operand width.
package adder_pkg;

  localparam int unsigned ADDER_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, purely combinational.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic SUM,
  output logic CARRY
);

  assign SUM   = A ^ B ^ Cin;
  assign CARRY = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: sequences one shared full_adder over WIDTH
// clocks, LSB first, and publishes the registered sum with a done pulse.
module serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT
);

  localparam int unsigned      CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // The LSB of the sum shift register is shifted out before it is ever read,
  // so only the upper WIDTH-1 bits are stored; sum_cat is the shifted-in view.
  logic [WIDTH-2:0] sum_sh;
  logic [WIDTH-1:0] sum_cat;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s;
  logic             c;
  logic             accept;
  logic             last_bit;

  full_adder u_fa (
    .A     (a_sh[0]),
    .B     (b_sh[0]),
    .Cin   (carry),
    .SUM   (s),
    .CARRY (c)
  );

  assign accept   = start && (state != RUN);
  assign last_bit = (state == RUN) && (cnt == LAST);
  assign sum_cat  = {s, sum_sh};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == LAST) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      SUM    <= '0;
      COUT   <= 1'b0;
    end else if (accept) begin
      a_sh   <= A;
      b_sh   <= B;
      sum_sh <= '0;
      carry  <= Cin;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= sum_cat[WIDTH-1:1];
      carry  <= c;
      cnt    <= cnt + 1'b1;
      if (last_bit) begin
        SUM  <= sum_cat;
        COUT <= c;
      end
    end
  end

  // Both flags decode the state register only, so start never reaches them
  // combinationally.
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomised checks of serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       Cin;
  logic       busy;
  logic       done;
  logic [7:0] SUM;
  logic       COUT;

  int n_checks = 0;
  int n_fail   = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .busy  (busy),
    .done  (done),
    .SUM   (SUM),
    .COUT  (COUT)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Issues one start pulse from the posedge+1 phase and waits (bounded) for
  // done. Returns latency, busy cycles seen and whether SUM/COUT held steady.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       output int lat, output int busy_n, output logic stable);
    logic [7:0] s0;
    logic       c0;
    s0 = SUM;
    c0 = COUT;
    stable = 1'b1;
    A = a; B = b; Cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_n = busy ? 1 : 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (busy) busy_n++;
      if (SUM !== s0 || COUT !== c0) stable = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, SUM, COUT} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b SUM=%h COUT=%b, required all 0", busy, done, SUM, COUT);
    end
    #3 rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_basic;
    int lat, bn;
    logic st;
    do_op(8'h05, 8'h03, 1'b0, lat, bn, st);
    n_checks++;
    if (lat !== 8) begin n_fail++; $display("FAIL basic_latency: got %0d, required 8", lat); end
    n_checks++;
    if (bn !== 8) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d, required 8", bn); end
    n_checks++;
    if (SUM !== 8'h08 || COUT !== 1'b0) begin
      n_fail++; $display("FAIL basic_sum: got %b/%h, required 0/08", COUT, SUM);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_one_cycle: done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_carry;
    int lat, bn;
    logic st;
    do_op(8'hFF, 8'h01, 1'b0, lat, bn, st);
    n_checks++;
    if (SUM !== 8'h00 || COUT !== 1'b1 || lat !== 8) begin
      n_fail++; $display("FAIL carry_ff_01: got %b/%h lat %0d, required 1/00 lat 8", COUT, SUM, lat);
    end
    do_op(8'hFF, 8'hFF, 1'b1, lat, bn, st);
    n_checks++;
    if (SUM !== 8'hFF || COUT !== 1'b1 || lat !== 8) begin
      n_fail++; $display("FAIL carry_ff_ff_1: got %b/%h lat %0d, required 1/ff lat 8", COUT, SUM, lat);
    end
    n_checks++;
    if (!st) begin n_fail++; $display("FAIL carry_hold: SUM/COUT changed before done, required stable"); end
  endtask

  task automatic test_start_while_busy;
    int dones = 0;
    int first = 0;
    A = 8'h10; B = 8'h20; Cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 2) begin
        start = 1'b1; A = 8'hAA; B = 8'h55;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dones++;
        if (first == 0) first = i;
      end
    end
    n_checks++;
    if (dones !== 1) begin n_fail++; $display("FAIL busy_start_pulses: got %0d done pulses, required 1", dones); end
    n_checks++;
    if (first !== 8) begin n_fail++; $display("FAIL busy_start_latency: got %0d, required 8", first); end
    n_checks++;
    if (SUM !== 8'h30 || COUT !== 1'b0) begin
      n_fail++; $display("FAIL busy_start_sum: got %b/%h, required 0/30", COUT, SUM);
    end
  endtask

  task automatic test_back_to_back;
    int n = 0;
    int t1 = 0;
    int t2 = 0;
    int overlap = 0;
    A = 8'h0F; B = 8'h01; Cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    A = 8'h80; B = 8'h80;
    while (n < 40 && t2 == 0) begin
      @(posedge clk); #1;
      n++;
      if (busy && done) overlap++;
      if (done) begin
        if (t1 == 0) begin
          t1 = n;
          n_checks++;
          if (SUM !== 8'h10 || COUT !== 1'b0) begin
            n_fail++; $display("FAIL b2b_first_sum: got %b/%h, required 0/10", COUT, SUM);
          end
        end else begin
          t2 = n;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    n_checks++;
    if (t1 !== 8 || t2 - t1 !== 9) begin
      n_fail++; $display("FAIL b2b_spacing: done at %0d and %0d, required 8 and 17", t1, t2);
    end
    n_checks++;
    if (SUM !== 8'h00 || COUT !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second_sum: got %b/%h, required 1/00", COUT, SUM);
    end
    n_checks++;
    if (overlap !== 0) begin n_fail++; $display("FAIL b2b_overlap: busy&done seen %0d times, required 0", overlap); end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_release: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_op;
    int dones = 0;
    int lat, bn;
    logic st;
    A = 8'h7F; B = 8'h01; Cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy_before: busy=%b, required 1", busy); end
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, SUM, COUT} !== 11'd0) begin
      n_fail++;
      $display("FAIL rst_mid_immediate: busy=%b done=%b SUM=%h COUT=%b, required all 0", busy, done, SUM, COUT);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    n_checks++;
    if (dones !== 0) begin n_fail++; $display("FAIL rst_mid_no_done: activity seen %0d cycles, required 0", dones); end
    do_op(8'h02, 8'h02, 1'b0, lat, bn, st);
    n_checks++;
    if (SUM !== 8'h04 || COUT !== 1'b0 || lat !== 8) begin
      n_fail++; $display("FAIL rst_mid_next_op: got %b/%h lat %0d, required 0/04 lat 8", COUT, SUM, lat);
    end
  endtask

  task automatic test_random;
    logic [7:0] a, b;
    logic       ci;
    logic [8:0] exp_val;
    int lat, bn;
    logic st;
    for (int i = 0; i < 256; i++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      ci = 1'($urandom);
      exp_val = {1'b0, a} + {1'b0, b} + {8'd0, ci};
      do_op(a, b, ci, lat, bn, st);
      n_checks++;
      if ({COUT, SUM} !== exp_val || lat !== 8) begin
        n_fail++;
        $display("FAIL random_%0d: %h+%h+%b got %h lat %0d, required %h lat 8", i, a, b, ci, {COUT, SUM}, lat, exp_val);
      end
      n_checks++;
      if (!st) begin n_fail++; $display("FAIL random_hold_%0d: SUM/COUT changed before done, required stable", i); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
